vector_engine: RTL and testbench

- Synthesisable, parametrised stimulus/check engine for on-chip self-test of the multicycle core or any clocked block.
- Holds a vector memory. For each vector it drives the stimulus into the device under test, waits a set number of settle cycles, then compares the DUT outputs against the expected value under a per-bit mask.
- Counts vectors and errors and captures the first failure.
- Adds a load port, per-bit don't-care masks, configurable settle delay and stop-on-first-error mode.

---
 rtl/vector_engine_pkg.sv | 47 ++++
 rtl/vector_ram.sv | 32 +++
 rtl/vector_engine.sv | 164 ++++++++++++++++
 tb/tb_vector_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_engine_pkg.sv
// Shared definitions for the vector engine: FSM encoding and vector word layout.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package vector_engine_pkg;

  // 3-bit state encoding shared by the FSM and anyone probing it.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_APPLY = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_APPLY = ST_APPLY,
    S_WAIT  = ST_WAIT,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_t;

  // Settle counter is 4 bits wide, enough for a delay of 0..15.
  localparam int SETTLE_CNT_W = 4;

  // Vector word layout, MSB to LSB: {valid, mask, stim, expected}.
  function automatic int vw_width(input int in_w, input int out_w);
    return 1 + out_w + in_w + out_w;
  endfunction

  function automatic int vw_exp_lsb(input int in_w, input int out_w);
    return 0 * (in_w + out_w);
  endfunction

  function automatic int vw_stim_lsb(input int in_w, input int out_w);
    return out_w + 0 * in_w;
  endfunction

  function automatic int vw_mask_lsb(input int in_w, input int out_w);
    return out_w + in_w;
  endfunction

  function automatic int vw_valid_bit(input int in_w, input int out_w);
    return out_w + in_w + out_w;
  endfunction

endpackage

// File: rtl/vector_ram.sv
// Vector memory: one write port, one registered read port, contents not reset.
// Latency: read data valid one cycle after the read address is presented.
// Backpressure: none; write and read are accepted every cycle.
module vector_ram #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 27
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_dat
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  // Write port: store the word when enabled.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read port: registered output, one cycle latency.
  always_ff @(posedge CLK) begin
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/vector_engine.sv
// Self-test engine: replays stored vectors into a DUT and checks masked outputs.
// Latency: 3 + SETTLE cycles per vector, plus 2 cycles to read the terminating word.
// Backpressure: none; START while busy is ignored, loads while busy are dropped.
import vector_engine_pkg::*;

module vector_engine #(
  parameter int IN_W        = 2,
  parameter int OUT_W       = 12,
  parameter int ADDR_W      = 10,
  parameter int SETTLE      = 1,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           START,
  input  logic                           LD_EN,
  input  logic [ADDR_W-1:0]              LD_ADDR,
  input  logic [1+OUT_W+IN_W+OUT_W-1:0]  LD_DATA,
  input  logic [OUT_W-1:0]               DUT_OUT,
  output logic [IN_W-1:0]                STIM,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           PASS,
  output logic [CNT_W-1:0]               VEC_COUNT,
  output logic [CNT_W-1:0]               ERR_COUNT,
  output logic [ADDR_W-1:0]              FIRST_ERR_ADDR,
  output logic [OUT_W-1:0]               FIRST_ERR_GOT
);

  localparam int WORD_W    = vw_width(IN_W, OUT_W);
  localparam int EXP_LSB   = vw_exp_lsb(IN_W, OUT_W);
  localparam int STIM_LSB  = vw_stim_lsb(IN_W, OUT_W);
  localparam int MASK_LSB  = vw_mask_lsb(IN_W, OUT_W);
  localparam int VALID_BIT = vw_valid_bit(IN_W, OUT_W);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LD = SETTLE_CNT_W'(SETTLE);

  state_t                  state;
  logic [ADDR_W-1:0]       addr;
  logic [OUT_W-1:0]        exp_q;
  logic [OUT_W-1:0]        mask_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt;

  logic [WORD_W-1:0]       rd_dat;
  logic                    ram_wr_en;
  logic                    w_valid;
  logic [OUT_W-1:0]        w_mask;
  logic [IN_W-1:0]         w_stim;
  logic [OUT_W-1:0]        w_exp;
  logic                    mismatch;

  // Loading is only safe while no run is reading the memory.
  assign ram_wr_en = LD_EN && ((state == S_IDLE) || (state == S_DONE));

  vector_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (ram_wr_en),
    .wr_addr (LD_ADDR),
    .wr_dat  (LD_DATA),
    .rd_addr (addr),
    .rd_dat  (rd_dat)
  );

  assign w_valid = rd_dat[VALID_BIT];
  assign w_mask  = rd_dat[MASK_LSB +: OUT_W];
  assign w_stim  = rd_dat[STIM_LSB +: IN_W];
  assign w_exp   = rd_dat[EXP_LSB +: OUT_W];

  // Mask bit set means that output bit is don't-care.
  assign mismatch = |((DUT_OUT ^ exp_q) & ~mask_q);

  // PASS is only meaningful once the run has finished.
  assign PASS = DONE && (ERR_COUNT == '0);

  // Run sequencer: fetch, apply, settle, check; counters and capture ride along.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      addr           <= '0;
      exp_q          <= '0;
      mask_q         <= '0;
      settle_cnt     <= '0;
      STIM           <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      VEC_COUNT      <= '0;
      ERR_COUNT      <= '0;
      FIRST_ERR_ADDR <= '0;
      FIRST_ERR_GOT  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            addr           <= '0;
            VEC_COUNT      <= '0;
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
            FIRST_ERR_GOT  <= '0;
            BUSY           <= 1'b1;
            DONE           <= 1'b0;
            state          <= S_FETCH;
          end
        end

        S_FETCH: begin
          state <= S_APPLY;
        end

        S_APPLY: begin
          if (!w_valid) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            STIM       <= w_stim;
            exp_q      <= w_exp;
            mask_q     <= w_mask;
            settle_cnt <= SETTLE_LD;
            state      <= (SETTLE_LD == '0) ? S_CHECK : S_WAIT;
          end
        end

        S_WAIT: begin
          settle_cnt <= settle_cnt - SETTLE_CNT_W'(1);
          if (settle_cnt <= SETTLE_CNT_W'(1)) begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          VEC_COUNT <= VEC_COUNT + CNT_W'(1);
          if (mismatch) begin
            if (!(&ERR_COUNT)) begin
              ERR_COUNT <= ERR_COUNT + CNT_W'(1);
            end
            if (ERR_COUNT == '0) begin
              FIRST_ERR_ADDR <= addr;
              FIRST_ERR_GOT  <= DUT_OUT;
            end
          end
          if ((mismatch && (STOP_ON_ERR != 0)) || (&addr)) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= S_FETCH;
          end
        end

        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_engine.sv
// Bench for vector_engine: three instances (default, stop-on-error, 4-deep memory).
// Latency: results checked when DONE rises, against a queue of expected run totals.
// Backpressure: none; each run is bounded by a cycle budget.
module tb_vector_engine;

  localparam int IN_W   = 2;
  localparam int OUT_W  = 12;
  localparam int WORD_W = 1 + OUT_W + IN_W + OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [2:0]        start;
  logic [2:0]        ld_en;
  logic [9:0]        ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic [OUT_W-1:0]  lut [0:3];

  // Instance a: defaults
  logic [IN_W-1:0]  stim_a;
  logic             busy_a, done_a, pass_a;
  logic [15:0]      vec_a, err_a;
  logic [9:0]       fea_a;
  logic [OUT_W-1:0] feg_a, dut_out_a;
  // Instance s: stop on first error
  logic [IN_W-1:0]  stim_s;
  logic             busy_s, done_s, pass_s;
  logic [15:0]      vec_s, err_s;
  logic [9:0]       fea_s;
  logic [OUT_W-1:0] feg_s, dut_out_s;
  // Instance m: ADDR_W = 2
  logic [IN_W-1:0]  stim_m;
  logic             busy_m, done_m, pass_m;
  logic [15:0]      vec_m, err_m;
  logic [1:0]       fea_m;
  logic [OUT_W-1:0] feg_m, dut_out_m;

  vector_engine u_a (
    .CLK(clk), .RESET(reset), .START(start[0]), .LD_EN(ld_en[0]),
    .LD_ADDR(ld_addr), .LD_DATA(ld_data), .DUT_OUT(dut_out_a),
    .STIM(stim_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
    .VEC_COUNT(vec_a), .ERR_COUNT(err_a),
    .FIRST_ERR_ADDR(fea_a), .FIRST_ERR_GOT(feg_a)
  );

  vector_engine #(.STOP_ON_ERR(1)) u_s (
    .CLK(clk), .RESET(reset), .START(start[1]), .LD_EN(ld_en[1]),
    .LD_ADDR(ld_addr), .LD_DATA(ld_data), .DUT_OUT(dut_out_s),
    .STIM(stim_s), .BUSY(busy_s), .DONE(done_s), .PASS(pass_s),
    .VEC_COUNT(vec_s), .ERR_COUNT(err_s),
    .FIRST_ERR_ADDR(fea_s), .FIRST_ERR_GOT(feg_s)
  );

  vector_engine #(.ADDR_W(2)) u_m (
    .CLK(clk), .RESET(reset), .START(start[2]), .LD_EN(ld_en[2]),
    .LD_ADDR(ld_addr[1:0]), .LD_DATA(ld_data), .DUT_OUT(dut_out_m),
    .STIM(stim_m), .BUSY(busy_m), .DONE(done_m), .PASS(pass_m),
    .VEC_COUNT(vec_m), .ERR_COUNT(err_m),
    .FIRST_ERR_ADDR(fea_m), .FIRST_ERR_GOT(feg_m)
  );

  // Modelled DUTs: one-cycle registered lookup of the stimulus.
  always @(posedge clk) begin
    dut_out_a <= lut[stim_a];
    dut_out_s <= lut[stim_s];
    dut_out_m <= lut[stim_m];
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [31:0] vec;
    logic [31:0] err;
    logic [31:0] pass;
    logic [31:0] fea;
    logic [31:0] feg;
    string       tag;
  } exp_t;

  exp_t sbq [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic expect_run(input int inst, input int vec, input int err, input int pass,
                            input int fea, input int feg, input string tag);
    exp_t e;
    e.inst = inst;
    e.vec  = 32'(vec);
    e.err  = 32'(err);
    e.pass = 32'(pass);
    e.fea  = 32'(fea);
    e.feg  = 32'(feg);
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic check_result(input int inst, input logic [31:0] vec, input logic [31:0] err,
                              input logic [31:0] pass, input logic [31:0] fea,
                              input logic [31:0] feg);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done inst=%0d got=done required=no_run_pending", inst);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_inst"}, 32'(inst), 32'(e.inst));
      chk({e.tag, "_vec_count"}, vec, e.vec);
      chk({e.tag, "_err_count"}, err, e.err);
      chk({e.tag, "_pass"}, pass, e.pass);
      chk({e.tag, "_first_err_addr"}, fea, e.fea);
      chk({e.tag, "_first_err_got"}, feg, e.feg);
    end
  endtask

  // Monitors: compare totals whenever an instance enters DONE.
  logic done_prev_a = 1'b0, done_prev_s = 1'b0, done_prev_m = 1'b0;
  always @(negedge clk) begin
    if (done_a && !done_prev_a)
      check_result(0, 32'(vec_a), 32'(err_a), 32'(pass_a), 32'(fea_a), 32'(feg_a));
    if (done_s && !done_prev_s)
      check_result(1, 32'(vec_s), 32'(err_s), 32'(pass_s), 32'(fea_s), 32'(feg_s));
    if (done_m && !done_prev_m)
      check_result(2, 32'(vec_m), 32'(err_m), 32'(pass_m), 32'(fea_m), 32'(feg_m));
    done_prev_a = done_a;
    done_prev_s = done_s;
    done_prev_m = done_m;
  end

  function automatic logic [WORD_W-1:0] mkw(input logic v, input logic [OUT_W-1:0] m,
                                            input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e);
    return {v, m, s, e};
  endfunction

  function automatic logic done_of(input int inst);
    case (inst)
      0:       return done_a;
      1:       return done_s;
      default: return done_m;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int inst, input int a, input logic [WORD_W-1:0] w);
    ld_addr     = 10'(a);
    ld_data     = w;
    ld_en[inst] = 1'b1;
    tick();
    ld_en[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget, output int cyc);
    cyc = 0;
    while (!done_of(inst) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!done_of(inst)) begin
      checks++;
      failures++;
      $display("FAIL run_timeout inst=%0d got=not_done required=done_within_%0d", inst, budget);
    end
    tick();
    tick();
  endtask

  task automatic run(input int inst, input int budget, output int cyc);
    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
    wait_done(inst, budget, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset   = 1'b1;
    start   = '0;
    ld_en   = '0;
    ld_addr = '0;
    ld_data = '0;
    for (int i = 0; i < 4; i++) lut[i] = OUT_W'(i);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_stim", 32'(stim_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_vec", 32'(vec_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_fea", 32'(fea_a), 0);
    chk("rst_feg", 32'(feg_a), 0);

    // Three matching vectors then terminator: 3*4 vector cycles + 2 for the terminator
    for (int i = 0; i < 3; i++) load(0, i, mkw(1'b1, 12'h000, 2'b01, 12'h001));
    load(0, 3, mkw(1'b0, 12'h000, 2'b00, 12'h000));
    expect_run(0, 3, 0, 1, 0, 0, "loop");
    run(0, 200, cyc);
    chk("loop_latency", 32'(cyc), 14);

    // Vector 1 expects 0A5, DUT answers 0A4
    lut[2] = 12'h0A4;
    load(0, 0, mkw(1'b1, 12'h000, 2'b01, 12'h001));
    load(0, 1, mkw(1'b1, 12'h000, 2'b10, 12'h0A5));
    load(0, 2, mkw(1'b1, 12'h000, 2'b11, 12'h003));
    load(0, 3, mkw(1'b0, 12'h000, 2'b00, 12'h000));
    expect_run(0, 3, 1, 0, 1, 12'h0A4, "mis");
    run(0, 200, cyc);

    load(1, 0, mkw(1'b1, 12'h000, 2'b01, 12'h001));
    load(1, 1, mkw(1'b1, 12'h000, 2'b10, 12'h0A5));
    load(1, 2, mkw(1'b1, 12'h000, 2'b11, 12'h003));
    load(1, 3, mkw(1'b0, 12'h000, 2'b00, 12'h000));
    expect_run(1, 2, 1, 0, 1, 12'h0A4, "stop");
    run(1, 200, cyc);

    // Same mismatch hidden by a don't-care mask on bit 0
    load(0, 1, mkw(1'b1, 12'h001, 2'b10, 12'h0A5));
    expect_run(0, 3, 0, 1, 0, 0, "mask");
    run(0, 200, cyc);

    // Reset during WAIT of vector 2 (10 edges after the START edge)
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (10) tick();
    chk("pre_reset_vec", 32'(vec_a), 2);
    chk("pre_reset_busy", 32'(busy_a), 1);
    chk("pre_reset_stim", 32'(stim_a), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_stim", 32'(stim_a), 0);
    chk("mid_reset_busy", 32'(busy_a), 0);
    chk("mid_reset_vec", 32'(vec_a), 0);
    chk("mid_reset_err", 32'(err_a), 0);
    chk("mid_reset_done", 32'(done_a), 0);

    // START and RESET together: RESET wins
    reset    = 1'b1;
    start[0] = 1'b1;
    tick();
    reset    = 1'b0;
    start[0] = 1'b0;
    chk("start_reset_busy", 32'(busy_a), 0);

    expect_run(0, 3, 0, 1, 0, 0, "rerun");
    run(0, 200, cyc);

    // Load and START while busy must both be ignored
    load(0, 1, mkw(1'b1, 12'h000, 2'b10, 12'h0A5));
    expect_run(0, 3, 1, 0, 1, 12'h0A4, "busy_ops");
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    load(0, 0, mkw(1'b1, 12'h000, 2'b01, 12'hFFF));
    repeat (2) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, 200, cyc);
    chk("busy_ops_latency", 32'(7 + cyc), 14);

    expect_run(0, 3, 1, 0, 1, 12'h0A4, "busy_rerun");
    run(0, 200, cyc);

    // Empty memory
    load(0, 0, mkw(1'b0, 12'h000, 2'b01, 12'h001));
    expect_run(0, 0, 0, 1, 0, 0, "empty");
    run(0, 200, cyc);

    // Four-deep memory, all valid: stops at address 3, no wrap
    for (int i = 0; i < 4; i++) load(2, i, mkw(1'b1, 12'h000, 2'b01, 12'h001));
    expect_run(2, 4, 0, 1, 0, 0, "small");
    run(2, 200, cyc);
    chk("small_latency", 32'(cyc), 16);

    load(2, 0, mkw(1'b0, 12'h000, 2'b01, 12'h001));
    expect_run(2, 0, 0, 1, 0, 0, "small_empty");
    run(2, 200, cyc);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
